// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides sys_clk to the pixel rate and produces
// registered x/y counters, visible-area flag, syncs and pixel/frame strobes.
module vga_sync_gen #(
    parameter int unsigned SCREEN_WIDTH = 10,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    video_on,
    output logic                    p_tick,
    output logic                    frame_start,
    output logic [SCREEN_WIDTH-1:0] x,
    output logic [SCREEN_WIDTH-1:0] y
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]        div_cnt;
    logic [DIV_W-1:0]        div_nxt_c;
    logic                    adv_c;
    logic [SCREEN_WIDTH-1:0] h_nxt_c;
    logic [SCREEN_WIDTH-1:0] v_nxt_c;
    logic                    video_on_nxt_c;
    logic                    hsync_nxt_c;
    logic                    vsync_nxt_c;
    logic                    frame_start_nxt_c;

    // Next counter state; x/y are the counters themselves.
    always_comb begin
        adv_c     = (div_cnt == DIV_W'(CLK_DIV - 1));
        div_nxt_c = adv_c ? '0 : div_cnt + DIV_W'(1);
        h_nxt_c   = x;
        v_nxt_c   = y;
        if (adv_c) begin
            if (x == SCREEN_WIDTH'(H_TOTAL - 1)) begin
                h_nxt_c = '0;
                if (y == SCREEN_WIDTH'(V_TOTAL - 1)) begin
                    v_nxt_c = '0;
                end else begin
                    v_nxt_c = y + SCREEN_WIDTH'(1);
                end
            end else begin
                h_nxt_c = x + SCREEN_WIDTH'(1);
            end
        end
    end

    // Decodes from the next counter values so they register alongside x/y.
    always_comb begin
        video_on_nxt_c    = (h_nxt_c < SCREEN_WIDTH'(H_DISPLAY)) &&
                            (v_nxt_c < SCREEN_WIDTH'(V_DISPLAY));
        hsync_nxt_c       = !((h_nxt_c >= SCREEN_WIDTH'(HS_START)) &&
                              (h_nxt_c <  SCREEN_WIDTH'(HS_END)));
        vsync_nxt_c       = !((v_nxt_c >= SCREEN_WIDTH'(VS_START)) &&
                              (v_nxt_c <  SCREEN_WIDTH'(VS_END)));
        frame_start_nxt_c = adv_c && (h_nxt_c == '0) && (v_nxt_c == '0);
    end

    // Reset parks the counters on the last blanking pixel of the frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt     <= '0;
            x           <= SCREEN_WIDTH'(H_TOTAL - 1);
            y           <= SCREEN_WIDTH'(V_TOTAL - 1);
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            p_tick      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt_c;
            x           <= h_nxt_c;
            y           <= v_nxt_c;
            video_on    <= video_on_nxt_c;
            hsync       <= hsync_nxt_c;
            vsync       <= vsync_nxt_c;
            p_tick      <= adv_c;
            frame_start <= frame_start_nxt_c;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 build plus two reduced-geometry
// builds (15x10 total, CLK_DIV 4 and 1) so full frames fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       d0_hs, d0_vs, d0_vo, d0_pt, d0_fs;
    logic [9:0] d0_x, d0_y;
    logic       d1_hs, d1_vs, d1_vo, d1_pt, d1_fs;
    logic [9:0] d1_x, d1_y;
    logic       d2_hs, d2_vs, d2_vo, d2_pt, d2_fs;
    logic [9:0] d2_x, d2_y;

    vga_sync_gen d0 (
        .sys_clk(clk), .sys_rst(rst), .hsync(d0_hs), .vsync(d0_vs),
        .video_on(d0_vo), .p_tick(d0_pt), .frame_start(d0_fs), .x(d0_x), .y(d0_y)
    );

    // Small geometry: H 8+2+3+2=15 (hsync low x 10..12), V 6+1+2+1=10 (vsync low y 7..8)
    vga_sync_gen #(
        .SCREEN_WIDTH(10), .CLK_DIV(4),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) d1 (
        .sys_clk(clk), .sys_rst(rst), .hsync(d1_hs), .vsync(d1_vs),
        .video_on(d1_vo), .p_tick(d1_pt), .frame_start(d1_fs), .x(d1_x), .y(d1_y)
    );

    vga_sync_gen #(
        .SCREEN_WIDTH(10), .CLK_DIV(1),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) d2 (
        .sys_clk(clk), .sys_rst(rst), .hsync(d2_hs), .vsync(d2_vs),
        .video_on(d2_vo), .p_tick(d2_pt), .frame_start(d2_fs), .x(d2_x), .y(d2_y)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int n;
        int x, y, vo, hs, vs, pt, fs;
        int x2, y2;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int n;
        int pt1_cnt, pt1_last, pt1_gap_err, fs1_cnt, fs1_edge;
        int vs1_low, vs1_rng_err, vo1_err, hs1_low;
        int pt2_cnt, fs2_cnt, fs2_last, fs2_gap_err, x2_err, prev_x2;
        int vo0_cnt, hs0_low, hs0_fall_x, hs0_rise_x, prev_hs0;
        int glitch;

        // edge n after reset release: d1 pixel n/4-1, d2 pixel n-1
        vecs[0]  = '{1,   14, 9, 0, 1, 1, 0, 0,  0, 0};
        vecs[1]  = '{4,    0, 0, 1, 1, 1, 1, 1,  3, 0};
        vecs[2]  = '{5,    0, 0, 1, 1, 1, 0, 0,  4, 0};
        vecs[3]  = '{7,    0, 0, 1, 1, 1, 0, 0,  6, 0};
        vecs[4]  = '{8,    1, 0, 1, 1, 1, 1, 0,  7, 0};
        vecs[5]  = '{36,   8, 0, 0, 1, 1, 1, 0,  5, 2};
        vecs[6]  = '{44,  10, 0, 0, 0, 1, 1, 0, 13, 2};
        vecs[7]  = '{47,  10, 0, 0, 0, 1, 0, 0,  1, 3};
        vecs[8]  = '{52,  12, 0, 0, 0, 1, 1, 0,  6, 3};
        vecs[9]  = '{56,  13, 0, 0, 1, 1, 1, 0, 10, 3};
        vecs[10] = '{60,  14, 0, 0, 1, 1, 1, 0, 14, 3};
        vecs[11] = '{64,   0, 1, 1, 1, 1, 1, 0,  3, 4};
        vecs[12] = '{364,  0, 6, 0, 1, 1, 1, 0,  3, 4};
        vecs[13] = '{424,  0, 7, 0, 1, 0, 1, 0,  3, 8};
        vecs[14] = '{540, 14, 8, 0, 1, 0, 1, 0, 14, 5};
        vecs[15] = '{544,  0, 9, 0, 1, 1, 1, 0,  3, 6};
        vecs[16] = '{600, 14, 9, 0, 1, 1, 1, 0, 14, 9};
        vecs[17] = '{604,  0, 0, 1, 1, 1, 1, 1,  3, 0};

        // Reset values
        @(negedge clk);
        repeat (5) step();
        chk("rst_d0_x", int'(d0_x), 799);
        chk("rst_d0_y", int'(d0_y), 524);
        chk("rst_d0_vo", int'(d0_vo), 0);
        chk("rst_d0_hs", int'(d0_hs), 1);
        chk("rst_d0_vs", int'(d0_vs), 1);
        chk("rst_d0_pt", int'(d0_pt), 0);
        chk("rst_d0_fs", int'(d0_fs), 0);
        chk("rst_d1_x", int'(d1_x), 14);
        chk("rst_d1_y", int'(d1_y), 9);
        chk("rst_d2_pt", int'(d2_pt), 0);

        // Table walk
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 18; k++) begin
            while (n < vecs[k].n) begin
                step();
                n++;
            end
            chk($sformatf("v%0d_x", k),  int'(d1_x),  vecs[k].x);
            chk($sformatf("v%0d_y", k),  int'(d1_y),  vecs[k].y);
            chk($sformatf("v%0d_vo", k), int'(d1_vo), vecs[k].vo);
            chk($sformatf("v%0d_hs", k), int'(d1_hs), vecs[k].hs);
            chk($sformatf("v%0d_vs", k), int'(d1_vs), vecs[k].vs);
            chk($sformatf("v%0d_pt", k), int'(d1_pt), vecs[k].pt);
            chk($sformatf("v%0d_fs", k), int'(d1_fs), vecs[k].fs);
            chk($sformatf("v%0d_x2", k), int'(d2_x),  vecs[k].x2);
            chk($sformatf("v%0d_y2", k), int'(d2_y),  vecs[k].y2);
            chk($sformatf("v%0d_pt2", k), int'(d2_pt), 1);
        end

        // One full small frame, starting just after a d1 frame_start
        pt1_cnt = 0; pt1_last = 0; pt1_gap_err = 0; fs1_cnt = 0; fs1_edge = -1;
        vs1_low = 0; vs1_rng_err = 0; vo1_err = 0; hs1_low = 0;
        pt2_cnt = 0; fs2_cnt = 0; fs2_last = -3; fs2_gap_err = 0; x2_err = 0;
        prev_x2 = int'(d2_x);
        for (int i = 1; i <= 600; i++) begin
            step();
            if (d1_pt) begin
                pt1_cnt++;
                if (i - pt1_last != 4) pt1_gap_err++;
                pt1_last = i;
            end
            if (d1_fs) begin
                fs1_cnt++;
                fs1_edge = i;
            end
            if (!d1_vs) begin
                vs1_low++;
                if (d1_y < 10'd7 || d1_y > 10'd8) vs1_rng_err++;
            end
            if (d1_vo && d1_y >= 10'd6) vo1_err++;
            if (!d1_hs) hs1_low++;
            if (d2_pt) pt2_cnt++;
            if (d2_fs) begin
                fs2_cnt++;
                if (i - fs2_last != 150) fs2_gap_err++;
                fs2_last = i;
            end
            if (int'(d2_x) != (prev_x2 + 1) % 15) x2_err++;
            prev_x2 = int'(d2_x);
        end
        chk("frm1_pt_cnt", pt1_cnt, 150);
        chk("frm1_pt_gap_err", pt1_gap_err, 0);
        chk("frm1_fs_cnt", fs1_cnt, 1);
        chk("frm1_fs_period", fs1_edge, 600);
        chk("frm1_vs_low_clks", vs1_low, 120);
        chk("frm1_vs_range_err", vs1_rng_err, 0);
        chk("frm1_vo_blank_err", vo1_err, 0);
        chk("frm1_hs_low_clks", hs1_low, 120);
        chk("frm2_pt_cnt", pt2_cnt, 600);
        chk("frm2_fs_cnt", fs2_cnt, 4);
        chk("frm2_fs_gap_err", fs2_gap_err, 0);
        chk("frm2_x_inc_err", x2_err, 0);

        // One default 800-pixel line
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        vo0_cnt = 0; hs0_low = 0; hs0_fall_x = -1; hs0_rise_x = -1; prev_hs0 = 1;
        for (int e = 1; e <= 3204; e++) begin
            step();
            if (e == 3) begin
                chk("line_pre_x", int'(d0_x), 799);
                chk("line_pre_pt", int'(d0_pt), 0);
            end
            if (e == 4) begin
                chk("line_first_x", int'(d0_x), 0);
                chk("line_first_y", int'(d0_y), 0);
                chk("line_first_vo", int'(d0_vo), 1);
                chk("line_first_pt", int'(d0_pt), 1);
                chk("line_first_fs", int'(d0_fs), 1);
            end
            if (e >= 4 && e <= 3203) begin
                if (d0_vo) vo0_cnt++;
                if (!d0_hs) hs0_low++;
                if (prev_hs0 == 1 && !d0_hs) hs0_fall_x = int'(d0_x);
                if (prev_hs0 == 0 && d0_hs) hs0_rise_x = int'(d0_x);
                prev_hs0 = int'(d0_hs);
            end
            if (e == 3203) begin
                chk("line_end_x", int'(d0_x), 799);
                chk("line_end_y", int'(d0_y), 0);
            end
            if (e == 3204) begin
                chk("line_wrap_x", int'(d0_x), 0);
                chk("line_wrap_y", int'(d0_y), 1);
                chk("line_wrap_pt", int'(d0_pt), 1);
                chk("line_wrap_fs", int'(d0_fs), 0);
            end
        end
        chk("line_vo_clks", vo0_cnt, 2560);
        chk("line_hs_low_clks", hs0_low, 384);
        chk("line_hs_fall_x", hs0_fall_x, 656);
        chk("line_hs_rise_x", hs0_rise_x, 752);

        // Mid-frame reset while d1 sits inside both sync pulses
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (470) step();
        chk("mid_pre_x", int'(d1_x), 11);
        chk("mid_pre_y", int'(d1_y), 7);
        chk("mid_pre_hs", int'(d1_hs), 0);
        chk("mid_pre_vs", int'(d1_vs), 0);
        chk("mid_pre_d0_x", int'(d0_x), 116);
        rst = 1'b1;
        step();
        chk("mid_rst_x", int'(d1_x), 14);
        chk("mid_rst_y", int'(d1_y), 9);
        chk("mid_rst_hs", int'(d1_hs), 1);
        chk("mid_rst_vs", int'(d1_vs), 1);
        chk("mid_rst_vo", int'(d1_vo), 0);
        chk("mid_rst_pt", int'(d1_pt), 0);
        chk("mid_rst_fs", int'(d1_fs), 0);
        chk("mid_rst_d0_x", int'(d0_x), 799);
        chk("mid_rst_d0_y", int'(d0_y), 524);
        glitch = 0;
        repeat (2) begin
            step();
            if (!d1_hs || !d1_vs || d1_pt) glitch++;
        end
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            if (!d1_hs || !d1_vs || d1_pt || d1_fs) glitch++;
        end
        chk("mid_glitch", glitch, 0);
        step();
        chk("mid_restart_x", int'(d1_x), 0);
        chk("mid_restart_y", int'(d1_y), 0);
        chk("mid_restart_pt", int'(d1_pt), 1);
        chk("mid_restart_fs", int'(d1_fs), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator for the display path. It divides `sys_clk` down to the pixel rate and runs the horizontal and vertical counters. It drives the panel's `hsync`/`vsync` and supplies `video_on`, `x` and `y` to the pixel generator, which returns `rgb` for the same pixel. All outputs are registered from a single counter state, so `x`, `y`, `video_on`, `hsync` and `vsync` always describe the same pixel.

## Interface
Parameters:
- `SCREEN_WIDTH`, 10, width of the `x`/`y` outputs; must hold `H_TOTAL-1` and `V_TOTAL-1`.
- `CLK_DIV`, 4, `sys_clk` cycles per pixel (100 MHz → 25 MHz); legal values ≥1.
- `H_DISPLAY`, 640, visible pixels per line.
- `H_FRONT`, 16, horizontal front porch, in pixels.
- `H_SYNC`, 96, horizontal sync width, in pixels.
- `H_BACK`, 48, horizontal back porch, in pixels.
- `V_DISPLAY`, 480, visible lines.
- `V_FRONT`, 10, vertical front porch, in lines.
- `V_SYNC`, 2, vertical sync width, in lines.
- `V_BACK`, 33, vertical back porch, in lines.
- Derived: `H_TOTAL` = sum of the four H_* parameters = 800; `V_TOTAL` = sum of the four V_* parameters = 525.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `video_on`  out  1  high while the current pixel is in the visible area.
- `p_tick`  out  1  one-`sys_clk` strobe marking the first cycle of each new pixel.
- `frame_start`  out  1  strobe coincident with `p_tick` when (`x`,`y`) becomes (0,0).
- `x`  out  `SCREEN_WIDTH`  current horizontal count, 0..`H_TOTAL-1`.
- `y`  out  `SCREEN_WIDTH`  current vertical count, 0..`V_TOTAL-1`.

## Operation
- Divider `div_cnt` counts 0..`CLK_DIV-1` and wraps. Internal `adv` = (`div_cnt` == `CLK_DIV-1`).
- On each edge with `adv` high:
  - `h_cnt` increments.
  - At `H_TOTAL-1`, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At `V_TOTAL-1`, `v_cnt` wraps to 0.
- Output decodes are computed from the next (`h_cnt`,`v_cnt`) values and registered on the same edge:
  - `video_on` = h < `H_DISPLAY` && v < `V_DISPLAY`.
  - `hsync` = 0 iff `H_DISPLAY+H_FRONT` ≤ h < `H_DISPLAY+H_FRONT+H_SYNC`, i.e. h in 656..751 by default.
  - `vsync` = 0 iff `V_DISPLAY+V_FRONT` ≤ v < `V_DISPLAY+V_FRONT+V_SYNC`, i.e. v in 490..491 by default.
  - `x` = h and `y` = v.
- `p_tick` register is loaded with `adv` every cycle. `frame_start` register is loaded with `adv` && next (h,v) == (0,0).
- `CLK_DIV`=1: `adv` is constantly high. `p_tick` is 1 on every cycle after the first post-reset edge, and the counters advance every cycle.

## Timing
- Reset (synchronous, any cycle, including mid-frame):
  - `div_cnt`=0, `h_cnt`=`H_TOTAL-1`, `v_cnt`=`V_TOTAL-1`.
  - Outputs: `x`=799, `y`=524, `video_on`=0, `hsync`=1, `vsync`=1, `p_tick`=0, `frame_start`=0.
  - This state lies in the blanking/back-porch region, so reset never produces a spurious sync pulse.
- First pixel after reset: on the `CLK_DIV`-th rising edge after `sys_rst` falls, the outputs become `x`=0, `y`=0, `video_on`=1, `p_tick`=1, `frame_start`=1.
- Each pixel's outputs are held for exactly `CLK_DIV` `sys_clk` cycles. `p_tick` is high only in the first of those cycles.
- Signal timing and periods:
  - All outputs change on the same edge; zero skew between `x`/`y` and the syncs.
  - Line period = `H_TOTAL*CLK_DIV` = 3200 clocks.
  - Frame period = `H_TOTAL*V_TOTAL*CLK_DIV` = 1,680,000 clocks.
  - `hsync` low width = 384 clocks.
  - `vsync` low width = 2 lines = 6400 clocks.
- Wrap at (799,524) → (0,0): `y` and `x` update on the same edge, with no intermediate (0,524) or (799,0) state.
- Reset asserted mid-frame returns to the reset state on the next edge. No partial pixel or extra `p_tick` is emitted.

## Test plan
- Reset values: hold `sys_rst` for 5 cycles → `x`=799, `y`=524, `video_on`=0, `hsync`=1, `vsync`=1, `p_tick`=0; release → (0,0), `p_tick`=`frame_start`=1 on the 4th edge.
- Horizontal timing: run one line from (0,0) → `video_on` high for 640 pixels (2560 clocks); `hsync` falls when `x`=656 and rises when `x`=752; `x` wraps 799→0 with `y` +1.
- Vertical timing: run one full frame → `vsync` low exactly while `y`=490..491; `video_on` is 0 for all `y` ≥ 480; next `frame_start` arrives 1,680,000 clocks after the first.
- Strobe cadence: count `p_tick` over one frame → 420,000 pulses, each spaced 4 clocks; `frame_start` pulses exactly once.
- Mid-frame reset: assert `sys_rst` at (300,200) → the next edge shows (799,524) with `hsync`=`vsync`=1, and there is no glitch on either sync.
- `CLK_DIV`=1 build: after reset, `x` increments every cycle and `p_tick` stays high; frame period = 420,000 clocks.
